// File: rtl/vctr_tx.sv
// vctr_tx: 8N1 UART transmitter for the vector link, fed through a small byte FIFO.
// Define VCTR_TX_CHECKSUM_EN to append an XOR checksum byte to every frame.
module vctr_tx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       clock,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    input  logic       tx_last,
    output logic       tx_ready,
    output logic       tx,
    output logic       tx_busy,
    output logic       tx_done
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [AW:0]   LVL_FULL = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    logic [8:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   lvl_q;
    logic          full, empty, push, pop, load, bit_end, ck_pend;
    logic [8:0]    rd_word;
    logic [7:0]    ld_byte;
    logic          ld_last;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [2:0]    bit_q;
    logic [7:0]    shift_q;
    logic          last_q, tx_q, busy_q, done_q;

    assign full     = (lvl_q == LVL_FULL);
    assign empty    = (lvl_q == '0);
    assign tx_ready = !full && !rst;
    assign push     = tx_valid && tx_ready;
    assign rd_word  = mem_q[rd_ptr_q];

    // A new byte is taken either from idle or on the very last stop cycle,
    // which is what makes consecutive bytes leave with no idle bit.
    assign bit_end = (cnt_q == CNT_LAST);
    assign load    = ((state_q == IDLE) || (state_q == STOP && bit_end)) && (!empty || ck_pend);
    assign pop     = load && !ck_pend;

    always_ff @(posedge clock) begin
        if (push) mem_q[wr_ptr_q] <= {tx_last, tx_data};
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            lvl_q    <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   lvl_q <= lvl_q + 1'b1;
                2'b01:   lvl_q <= lvl_q - 1'b1;
                default: ;
            endcase
        end
    end

`ifdef VCTR_TX_CHECKSUM_EN
    logic [7:0] ck_q;
    logic       ck_pend_q;

    assign ck_pend = ck_pend_q;
    assign ld_byte = ck_pend_q ? ck_q : rd_word[7:0];
    assign ld_last = ck_pend_q;

    // Checksum byte has priority over the next frame's first byte.
    always_ff @(posedge clock) begin
        if (rst) begin
            ck_q      <= '0;
            ck_pend_q <= 1'b0;
        end else if (load && ck_pend_q) begin
            ck_q      <= '0;
            ck_pend_q <= 1'b0;
        end else if (pop) begin
            ck_q <= ck_q ^ rd_word[7:0];
            if (rd_word[8]) ck_pend_q <= 1'b1;
        end
    end
`else
    assign ck_pend = 1'b0;
    assign ld_byte = rd_word[7:0];
    assign ld_last = rd_word[8];
`endif

    // Line outputs are registered from the current state, so tx trails the FSM by one cycle.
    always_ff @(posedge clock) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            last_q  <= 1'b0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            tx_q   <= (state_q == START) ? 1'b0 : (state_q == DATA) ? shift_q[0] : 1'b1;
            busy_q <= (state_q != IDLE) || !empty;
            done_q <= (state_q == STOP) && bit_end && last_q;
            case (state_q)
                IDLE: begin
                    if (load) begin
                        state_q <= START;
                        cnt_q   <= '0;
                    end
                end
                START: begin
                    if (bit_end) begin
                        state_q <= DATA;
                        cnt_q   <= '0;
                        bit_q   <= '0;
                    end else cnt_q <= cnt_q + 1'b1;
                end
                DATA: begin
                    if (bit_end) begin
                        cnt_q   <= '0;
                        shift_q <= shift_q >> 1;
                        bit_q   <= bit_q + 1'b1;
                        if (bit_q == 3'd7) state_q <= STOP;
                    end else cnt_q <= cnt_q + 1'b1;
                end
                STOP: begin
                    if (bit_end) begin
                        cnt_q   <= '0;
                        state_q <= load ? START : IDLE;
                    end else cnt_q <= cnt_q + 1'b1;
                end
                default: state_q <= IDLE;
            endcase
            if (load) begin
                shift_q <= ld_byte;
                last_q  <= ld_last;
            end
        end
    end

    assign tx      = tx_q;
    assign tx_busy = busy_q;
    assign tx_done = done_q;
endmodule

// File: tb/tb_vctr_tx.sv
// Directed bench for vctr_tx at CLKS_PER_BIT=4, FIFO_DEPTH=4; expected line built from a byte list.
module tb_vctr_tx;
    logic       clock = 1'b0;
    logic       rst = 1'b1;
    logic       tx_valid = 1'b0;
    logic       tx_last = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_ready, tx, tx_busy, tx_done;

    int         tests = 0;
    int         fails = 0;
    logic [7:0] eb [16];
    logic       el [16];
    int         en = 0;
    logic [7:0] txor = 8'h00;

    vctr_tx #(.CLKS_PER_BIT(4), .FIFO_DEPTH(4)) dut (
        .clock    (clock),
        .rst      (rst),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_last  (tx_last),
        .tx_ready (tx_ready),
        .tx       (tx),
        .tx_busy  (tx_busy),
        .tx_done  (tx_done)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Expected byte list; with checksum enabled the bench adds the XOR byte itself.
    task automatic add_b(input logic [7:0] b, input logic l);
`ifdef VCTR_TX_CHECKSUM_EN
        eb[en] = b; el[en] = 1'b0; en++;
        txor = txor ^ b;
        if (l) begin
            eb[en] = txor; el[en] = 1'b1; en++;
            txor = 8'h00;
        end
`else
        eb[en] = b; el[en] = l; en++;
`endif
    endtask

    // c counts cycles from the first sample at which the start bit shows on tx.
    function automatic logic exp_tx(input int c);
        int j, p;
        if (c >= en * 40) return 1'b1;
        j = c / 40;
        p = (c % 40) / 4;
        if (p == 0) return 1'b0;
        if (p == 9) return 1'b1;
        return eb[j][p-1];
    endfunction

    function automatic logic exp_done(input int c);
        if (c / 40 >= en) return 1'b0;
        return (c % 40 == 39) && el[c / 40];
    endfunction

    task automatic send_first(input logic [7:0] b, input logic l);
        tx_data = b; tx_last = l; tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
    endtask

    // Call right after the edge that accepted the first byte.
    task automatic monitor();
        tick();
        chk("pre_start_tx", {7'd0, tx}, 8'd1);
        for (int c = 0; c < en * 40 + 2; c++) begin
            tick();
            chk("tx_line", {7'd0, tx}, {7'd0, exp_tx(c)});
            chk("tx_done", {7'd0, tx_done}, {7'd0, exp_done(c)});
            if (c == 0) chk("busy_in_frame", {7'd0, tx_busy}, 8'd1);
        end
        chk("busy_after", {7'd0, tx_busy}, 8'd0);
    endtask

    initial begin
        repeat (3) tick();
        chk("rst_tx", {7'd0, tx}, 8'd1);
        chk("rst_busy", {7'd0, tx_busy}, 8'd0);
        chk("rst_done", {7'd0, tx_done}, 8'd0);
        chk("rst_ready", {7'd0, tx_ready}, 8'd0);
        rst = 1'b0;
        #1;
        chk("ready_after_rst", {7'd0, tx_ready}, 8'd1);

        // single byte A5
        en = 0; txor = 8'h00;
        add_b(8'hA5, 1'b1);
        send_first(8'hA5, 1'b1);
        monitor();

        // burst 1..6 with valid held, FIFO fills
        en = 0;
        for (int i = 1; i <= 6; i++) add_b(8'(i), i == 6);
        send_first(8'h01, 1'b0);
        fork
            begin
                for (int i = 2; i <= 6; i++) begin
                    int w;
                    tx_data = 8'(i); tx_last = (i == 6); tx_valid = 1'b1;
                    w = 0;
                    while (!tx_ready && w < 100) begin
                        tick();
                        w++;
                    end
                    chk("burst_rdy_wait", {7'd0, tx_ready}, 8'd1);
                    tick();
                    if (i == 5) chk("full_ready", {7'd0, tx_ready}, 8'd0);
                end
                tx_valid = 1'b0;
            end
            monitor();
        join

        // push on the pop edge that empties the FIFO
        en = 0;
        add_b(8'h55, 1'b0); add_b(8'h9A, 1'b0); add_b(8'h66, 1'b1);
        send_first(8'h55, 1'b0);
        fork
            begin
                tx_data = 8'h9A; tx_last = 1'b0; tx_valid = 1'b1;
                tick();
                tx_valid = 1'b0;
                repeat (39) tick();
                chk("push_pop_ready", {7'd0, tx_ready}, 8'd1);
                tx_data = 8'h66; tx_last = 1'b1; tx_valid = 1'b1;
                tick();
                tx_valid = 1'b0;
            end
            monitor();
        join

        // frame 12 34 56 (checksum 70 when enabled)
        en = 0;
        add_b(8'h12, 1'b0); add_b(8'h34, 1'b0); add_b(8'h56, 1'b1);
        send_first(8'h12, 1'b0);
        fork
            begin
                tx_data = 8'h34; tx_last = 1'b0; tx_valid = 1'b1;
                tick();
                tx_data = 8'h56; tx_last = 1'b1;
                tick();
                tx_valid = 1'b0;
            end
            monitor();
        join

        // alternating one-byte frames
        en = 0;
        add_b(8'hFF, 1'b1); add_b(8'h00, 1'b1);
        send_first(8'hFF, 1'b1);
        fork
            begin
                tx_data = 8'h00; tx_last = 1'b1; tx_valid = 1'b1;
                tick();
                tx_valid = 1'b0;
            end
            monitor();
        join

        // reset mid-DATA with two bytes still queued
        send_first(8'h3C, 1'b0);
        tx_data = 8'h11; tx_last = 1'b0; tx_valid = 1'b1;
        tick();
        tx_data = 8'h22; tx_last = 1'b1;
        tick();
        tx_valid = 1'b0;
        repeat (12) tick();
        chk("mid_frame_busy", {7'd0, tx_busy}, 8'd1);
        rst = 1'b1;
        tick();
        chk("midrst_tx", {7'd0, tx}, 8'd1);
        chk("midrst_busy", {7'd0, tx_busy}, 8'd0);
        chk("midrst_ready", {7'd0, tx_ready}, 8'd0);
        rst = 1'b0;
        #1;
        chk("midrst_ready_rel", {7'd0, tx_ready}, 8'd1);
        for (int i = 0; i < 45; i++) begin
            tick();
            chk("flushed_tx", {7'd0, tx}, 8'd1);
            chk("flushed_busy", {7'd0, tx_busy}, 8'd0);
        end
        en = 0; txor = 8'h00;
        add_b(8'h81, 1'b1);
        send_first(8'h81, 1'b1);
        monitor();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
